// File: rtl/elastic_holding_reg_pkg.sv
// Shared definitions for elastic_holding_reg.
// The state encoding doubles as the occupancy count, so the numeric values matter.
package elastic_holding_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/elastic_holding_reg_hold_data_reg.sv
// hold_data_reg: N-bit enable register with synchronous active-low reset.
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset, loads RESET_VAL
//   clr_i    synchronous clear to RESET_VAL (flush)
//   en_i     load d_i
//   d_i      next data
//   q_o      registered data
module hold_data_reg #(
  parameter int unsigned    N         = 32,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= RESET_VAL;
    end else if (clr_i) begin
      data_q <= RESET_VAL;
    end else if (en_i) begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/elastic_holding_reg.sv
// elastic_holding_reg: N-bit inter-stage register with valid/ready handshake and a
// 2-entry skid, so in_ready depends on registered state only. ELASTIC=0 turns it
// into a plain write-enable holding register.
//   clk, reset_n          clock, synchronous active-low reset
//   in_valid/in_ready     producer handshake (legacy: in_valid is the write enable)
//   in_data               producer data
//   out_valid/out_ready   consumer handshake (out_ready ignored in legacy mode)
//   out_data              head entry, straight from the main register
//   flush                 drop all held entries
//   count                 occupancy 0..2
module elastic_holding_reg
  import elastic_holding_reg_pkg::*;
#(
  parameter int unsigned  N         = 32,
  parameter logic [N-1:0] RESET_VAL = '0,
  parameter bit           ELASTIC   = 1'b1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  input  logic         flush,
  output logic [1:0]   count
);

  state_e       state_q, state_d;
  logic         push, pop;
  logic         main_en, main_sel_skid, skid_en;
  logic [N-1:0] main_d, main_q, skid_q;

  assign in_ready  = ELASTIC ? (state_q != ST_FULL) : 1'b1;
  assign out_valid = (state_q != ST_EMPTY);
  assign count     = state_q;
  assign out_data  = main_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    state_d       = state_q;
    main_en       = 1'b0;
    main_sel_skid = 1'b0;
    skid_en       = 1'b0;
    if (ELASTIC) begin
      case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_en = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_en = 1'b1;  // streaming: replace head in place
          end else if (push) begin
            skid_en = 1'b1;
            state_d = ST_FULL;
          end else if (pop) begin
            state_d = ST_EMPTY;  // main keeps the popped value
          end
        end
        ST_FULL: begin
          if (pop) begin
            main_en       = 1'b1;
            main_sel_skid = 1'b1;
            state_d       = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
      if (flush) state_d = ST_EMPTY;
    end else begin
      // Legacy: always valid once out of reset; flush only clears the data.
      main_en = in_valid;
      state_d = ST_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  assign main_d = main_sel_skid ? skid_q : in_data;

  hold_data_reg #(
    .N         (N),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (flush),
    .en_i    (main_en),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  hold_data_reg #(
    .N         (N),
    .RESET_VAL (RESET_VAL)
  ) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (flush),
    .en_i    (skid_en),
    .d_i     (in_data),
    .q_o     (skid_q)
  );

endmodule

// File: tb/tb_elastic_holding_reg.sv
module tb_elastic_holding_reg;

  localparam int unsigned N  = 32;
  localparam logic [31:0] RV = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        reset_n, in_valid, out_ready, flush;
  logic [31:0] in_data;

  logic        e_in_ready, e_out_valid;
  logic [31:0] e_out_data;
  logic [1:0]  e_count;
  logic        l_in_ready, l_out_valid;
  logic [31:0] l_out_data;
  logic [1:0]  l_count;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: elastic = FIFO queue of depth 2 plus the last visible head.
  logic [31:0] q[$];
  logic [31:0] last_head;
  // Legacy reference: a plain register with a valid flag.
  logic [31:0] l_main;
  logic        l_valid;

  always #5 clk = ~clk;

  elastic_holding_reg #(
    .N         (N),
    .RESET_VAL (RV),
    .ELASTIC   (1'b1)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (e_in_ready),
    .in_data   (in_data),
    .out_valid (e_out_valid),
    .out_ready (out_ready),
    .out_data  (e_out_data),
    .flush     (flush),
    .count     (e_count)
  );

  elastic_holding_reg #(
    .N         (N),
    .RESET_VAL (RV),
    .ELASTIC   (1'b0)
  ) u_legacy (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (l_in_ready),
    .in_data   (in_data),
    .out_valid (l_out_valid),
    .out_ready (out_ready),
    .out_data  (l_out_data),
    .flush     (flush),
    .count     (l_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance the model with the current inputs, clock once, then compare.
  task automatic tick();
    logic        m_push, m_pop;
    logic [31:0] exp_head;
    m_push = in_valid && (q.size() < 2);
    m_pop  = (q.size() > 0) && out_ready;
    if (!reset_n || flush) begin
      q.delete();
      last_head = RV;
    end else begin
      if (m_pop) last_head = q.pop_front();
      if (m_push) q.push_back(in_data);
    end
    if (!reset_n) begin
      l_main  = RV;
      l_valid = 1'b0;
    end else begin
      l_valid = 1'b1;
      if (flush) l_main = RV;
      else if (in_valid) l_main = in_data;
    end

    @(posedge clk);
    #1;
    exp_head = (q.size() > 0) ? q[0] : last_head;
    chk("e_count", {30'd0, e_count}, q.size());
    chk("e_out_valid", {31'd0, e_out_valid}, {31'd0, q.size() != 0});
    chk("e_in_ready", {31'd0, e_in_ready}, {31'd0, q.size() < 2});
    chk("e_out_data", e_out_data, exp_head);
    chk("l_out_data", l_out_data, l_main);
    chk("l_out_valid", {31'd0, l_out_valid}, {31'd0, l_valid});
    chk("l_in_ready", {31'd0, l_in_ready}, 32'd1);
    chk("l_count", {30'd0, l_count}, {31'd0, l_valid});
  endtask

  task automatic push_one(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    last_head = RV;
    l_main    = RV;
    l_valid   = 1'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    flush     = 1'b0;

    // Reset held two cycles with a push pending.
    tick();
    tick();
    reset_n  = 1'b1;
    in_valid = 1'b0;
    tick();

    // Streaming at one item per cycle.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = i;
      tick();
    end
    in_valid = 1'b0;
    tick();

    // Back-pressure fills the skid, then drains in order.
    out_ready = 1'b0;
    push_one(32'hA);
    push_one(32'hB);
    out_ready = 1'b1;
    tick();
    tick();

    // Flush beats a push while full.
    out_ready = 1'b0;
    push_one(32'hA);
    push_one(32'hB);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hC;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();

    // Reset while full with the consumer ready.
    push_one(32'h11);
    push_one(32'h22);
    out_ready = 1'b1;
    reset_n   = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();

    // Legacy load, hold, flush (elastic copy sees the same inputs).
    out_ready = 1'b0;
    push_one(32'h55);
    for (int i = 0; i < 5; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      reset_n   = ($urandom_range(0, 59) != 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
